hs32_execute3: RTL and testbench

Stage 3 (execute/writeback) of the hs32 pipeline: the consumer of the `hs32_s2pkt` stream produced by decode stage 2. It registers one packet and evaluates the ALU operation selected by `hs32_aluctl`. It writes the result to the regfile write port under an ack handshake and maintains the NZCV flags register. It drives the `rd3`/`stl3` hazard signals back to stage 2 and back-pressures stage 2 while a writeback is pending.

---
 rtl/hs32_execute3_pkg.sv | 35 +++
 rtl/hs32_alu.sv | 41 ++++
 rtl/hs32_execute3.sv | 71 +++++++
 tb/tb_hs32_execute3.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hs32_execute3_pkg.sv
// Shared hs32 pipeline types: the stage-2 packet, ALU control and the NZCV flags.
package hs32_execute3_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  typedef struct packed {
    logic [1:0] opr;
    logic       neg;
    logic       sub;
    logic       cen;
    logic       fwe;
  } hs32_aluctl;

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [3:0]        rd;
    logic              we1;
    logic              we2;
    hs32_aluctl        ctl;
  } hs32_s2pkt;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } hs32_flags;

endpackage

// File: rtl/hs32_alu.sv
// Combinational hs32 ALU: add/and/or/xor with optional operand-B inversion and carry chaining.
module hs32_alu
  import hs32_execute3_pkg::*;
(
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  hs32_aluctl        ctl_i,
  input  hs32_flags         flags_i,
  output logic [DATA_W-1:0] res_o,
  output hs32_flags         flags_o
);

  logic [DATA_W-1:0] b;
  logic              cin;
  logic [DATA_W:0]   sum;
  logic [1:0]        unused_nz;

  assign unused_nz = {flags_i.n, flags_i.z};

  always_comb begin
    b       = ctl_i.neg ? ~d2_i : d2_i;
    // cen chains the stored carry (adc/sbc); otherwise sub supplies the +1 of two's complement
    cin     = ctl_i.cen ? flags_i.c : ctl_i.sub;
    sum     = {1'b0, d1_i} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    res_o   = '0;
    flags_o = flags_i;
    case (ctl_i.opr)
      ALU_ADD: res_o = sum[DATA_W-1:0];
      ALU_AND: res_o = d1_i & b;
      ALU_OR:  res_o = d1_i | b;
      default: res_o = d1_i ^ b;
    endcase
    flags_o.n = res_o[DATA_W-1];
    flags_o.z = (res_o == '0);
    if (ctl_i.opr == ALU_ADD) begin
      flags_o.c = sum[DATA_W];
      flags_o.v = (d1_i[DATA_W-1] == b[DATA_W-1]) & (res_o[DATA_W-1] != d1_i[DATA_W-1]);
    end
  end

endmodule

// File: rtl/hs32_execute3.sv
// hs32 stage 3: holds one decoded packet, writes its ALU result back under an ack
// handshake, maintains NZCV and reports hazards/back-pressure to stage 2.
module hs32_execute3
  import hs32_execute3_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  hs32_s2pkt         data_i,
  input  logic              valid_i,
  output logic              stall_o,
  output logic [3:0]        rd3_o,
  output logic              stl3_o,
  output logic [3:0]        wp_addr_o,
  output logic [DATA_W-1:0] wp_data_o,
  output logic              wp_we_o,
  input  logic              wp_ack_i,
  output hs32_flags         flags_o
);

  logic              v_q;
  hs32_s2pkt         pkt_q;
  hs32_flags         flags_q;
  logic [DATA_W-1:0] alu_res;
  hs32_flags         alu_flags;
  logic              done;
  logic              accept;
  logic              unused_we2;

  assign unused_we2 = pkt_q.we2;

  hs32_alu u_alu (
    .d1_i    (pkt_q.d1),
    .d2_i    (pkt_q.d2),
    .ctl_i   (pkt_q.ctl),
    .flags_i (flags_q),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  // Handshake: a held write blocks stage 2 until the regfile acks it
  assign done    = v_q & (~pkt_q.we1 | wp_ack_i);
  assign stall_o = v_q & pkt_q.we1 & ~wp_ack_i;
  assign accept  = valid_i & ~stall_o;

  assign wp_we_o   = v_q & pkt_q.we1;
  assign wp_addr_o = pkt_q.rd;
  assign wp_data_o = alu_res;
  assign stl3_o    = wp_we_o;
  assign rd3_o     = pkt_q.rd;
  assign flags_o   = flags_q;

  // Stage register and flags commit
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= 1'b0;
      pkt_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        pkt_q <= data_i;
        v_q   <= 1'b1;
      end else if (done) begin
        v_q   <= 1'b0;
      end
      if (done && pkt_q.ctl.fwe) begin
        flags_q <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_hs32_execute3.sv
// Directed bench for hs32_execute3: table of single-op vectors plus back-pressure and reset sequences.
module tb_hs32_execute3;
  import hs32_execute3_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  hs32_s2pkt   data_i;
  logic        valid_i;
  logic        stall_o;
  logic [3:0]  rd3_o;
  logic        stl3_o;
  logic [3:0]  wp_addr_o;
  logic [31:0] wp_data_o;
  logic        wp_we_o;
  logic        wp_ack_i;
  hs32_flags   flags_o;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;

  hs32_execute3 dut (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .stall_o   (stall_o),
    .rd3_o     (rd3_o),
    .stl3_o    (stl3_o),
    .wp_addr_o (wp_addr_o),
    .wp_data_o (wp_data_o),
    .wp_we_o   (wp_we_o),
    .wp_ack_i  (wp_ack_i),
    .flags_o   (flags_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && wp_we_o && wp_ack_i) nwr <= nwr + 1;
  end

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  rd;
    logic        we1;
    logic [1:0]  opr;
    logic        neg;
    logic        sub;
    logic        cen;
    logic        fwe;
    logic        ack;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] rd,
                      input logic we1, input logic [1:0] opr, input logic neg,
                      input logic sub, input logic cen, input logic fwe);
    data_i         = '0;
    data_i.d1      = d1;
    data_i.d2      = d2;
    data_i.rd      = rd;
    data_i.we1     = we1;
    data_i.we2     = 1'b1;
    data_i.ctl.opr = opr;
    data_i.ctl.neg = neg;
    data_i.ctl.sub = sub;
    data_i.ctl.cen = cen;
    data_i.ctl.fwe = fwe;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, 32'(stall_o), 0);
    check({tag, ".we"},    32'(wp_we_o), 0);
    check({tag, ".stl3"},  32'(stl3_o), 0);
    check({tag, ".rd3"},   32'(rd3_o), 0);
    check({tag, ".addr"},  32'(wp_addr_o), 0);
    check({tag, ".data"},  wp_data_o, 0);
    check({tag, ".flags"}, 32'(flags_o), 0);
  endtask

  initial begin
    int wr0;
    //            d1            d2            rd we opr neg sub cen fwe ack  data          nzcv
    tbl[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'd3,  1, 2'd0, 0, 0, 0, 1, 1, 32'h80000000, 4'b1001};
    tbl[1]  = '{32'h00000005, 32'h00000005, 4'd4,  1, 2'd0, 1, 1, 0, 1, 1, 32'h00000000, 4'b0110};
    tbl[2]  = '{32'h00000000, 32'h00000000, 4'd5,  1, 2'd0, 0, 0, 1, 1, 1, 32'h00000001, 4'b0000};
    tbl[3]  = '{32'h80000000, 32'h80000000, 4'd6,  1, 2'd0, 0, 0, 0, 1, 1, 32'h00000000, 4'b0111};
    tbl[4]  = '{32'h000000FF, 32'h0000000F, 4'd7,  1, 2'd1, 1, 0, 0, 0, 1, 32'h000000F0, 4'b0111};
    tbl[5]  = '{32'h000000FF, 32'h0000000F, 4'd8,  1, 2'd1, 1, 0, 0, 1, 1, 32'h000000F0, 4'b0011};
    tbl[6]  = '{32'h80000000, 32'h00000001, 4'd9,  1, 2'd2, 0, 0, 0, 1, 1, 32'h80000001, 4'b1011};
    tbl[7]  = '{32'h0000FFFF, 32'h0000FFFF, 4'd10, 1, 2'd3, 0, 0, 0, 1, 1, 32'h00000000, 4'b0111};
    tbl[8]  = '{32'h0000000A, 32'h00000003, 4'd11, 1, 2'd0, 1, 0, 1, 1, 1, 32'h00000007, 4'b0010};
    tbl[9]  = '{32'h00000001, 32'h00000001, 4'd12, 1, 2'd0, 0, 0, 0, 1, 1, 32'h00000002, 4'b0000};
    tbl[10] = '{32'h00000005, 32'h00000005, 4'd13, 1, 2'd0, 1, 1, 1, 1, 1, 32'hFFFFFFFF, 4'b1000};
    tbl[11] = '{32'h00000002, 32'h00000003, 4'd14, 0, 2'd0, 0, 0, 0, 1, 0, 32'h00000005, 4'b0000};

    reset = 1'b1; valid_i = 1'b0; wp_ack_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    check_all_zero("reset");

    foreach (tbl[i]) begin
      @(negedge clk);
      load(tbl[i].d1, tbl[i].d2, tbl[i].rd, tbl[i].we1, tbl[i].opr,
           tbl[i].neg, tbl[i].sub, tbl[i].cen, tbl[i].fwe);
      valid_i = 1'b1; wp_ack_i = tbl[i].ack;
      @(posedge clk); @(negedge clk);
      valid_i = 1'b0; #1;
      check($sformatf("v%0d.we", i),    32'(wp_we_o), 32'(tbl[i].we1));
      check($sformatf("v%0d.stl3", i),  32'(stl3_o), 32'(tbl[i].we1));
      check($sformatf("v%0d.stall", i), 32'(stall_o), 0);
      check($sformatf("v%0d.addr", i),  32'(wp_addr_o), 32'(tbl[i].rd));
      check($sformatf("v%0d.rd3", i),   32'(rd3_o), 32'(tbl[i].rd));
      check($sformatf("v%0d.data", i),  wp_data_o, tbl[i].exp_data);
      @(posedge clk); @(negedge clk); #1;
      check($sformatf("v%0d.flags", i), 32'(flags_o), 32'(tbl[i].exp_flags));
      check($sformatf("v%0d.idle", i),  32'(stl3_o), 0);
    end
    check("table.writes", 32'(nwr), 11);

    // Back-pressure: A held for 3 unacked cycles while B waits, then B follows with no bubble
    wr0 = nwr;
    @(negedge clk);
    load(32'd1, 32'd2, 4'd1, 1, ALU_ADD, 0, 0, 0, 1);
    valid_i = 1'b1; wp_ack_i = 1'b0;
    @(posedge clk); @(negedge clk);
    load(32'hFFFFFFFF, 32'd1, 4'd2, 1, ALU_ADD, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.stall", k), 32'(stall_o), 1);
      check($sformatf("bp%0d.stl3", k),  32'(stl3_o), 1);
      check($sformatf("bp%0d.we", k),    32'(wp_we_o), 1);
      check($sformatf("bp%0d.addr", k),  32'(wp_addr_o), 1);
      check($sformatf("bp%0d.data", k),  wp_data_o, 32'd3);
      @(posedge clk); @(negedge clk);
    end
    wp_ack_i = 1'b1; #1;
    check("bp.ack_stall", 32'(stall_o), 0);
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0; #1;
    check("bp.flagsA", 32'(flags_o), 32'b0000);
    check("bp.B_we",   32'(wp_we_o), 1);
    check("bp.B_addr", 32'(wp_addr_o), 2);
    check("bp.B_data", wp_data_o, 32'h0);
    @(posedge clk); @(negedge clk); #1;
    check("bp.flagsB", 32'(flags_o), 32'b0110);
    check("bp.writes", 32'(nwr - wr0), 2);

    // Reset while a write is waiting for ack: dropped, no write, flags cleared
    wr0 = nwr;
    load(32'h7FFFFFFF, 32'd1, 4'd9, 1, ALU_ADD, 0, 0, 0, 1);
    valid_i = 1'b1; wp_ack_i = 1'b0;
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0; #1;
    check("rst.pre_we", 32'(wp_we_o), 1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; #1;
    check_all_zero("rst");
    check("rst.writes", 32'(nwr - wr0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
